// File: rtl/vga_sync_driver.sv
// vga_sync_driver: VGA timing generator (640x480@60 by default) with a clk/2 pixel clock.
// Latency: counters advance on the clk edge where vga_clk falls; all other outputs decode them combinationally.
// Backpressure: none, free-running; frame_done is a one-clk strobe that the consumer must not stall.
//
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   vga_clk               pixel clock (clk/2), driven straight from the phase flop
//   hsync, vsync          active-low sync pulses
//   active_pixels         high while (xPixel, yPixel) lies in the visible area
//   frame_done            one-clk strobe on the last clk of the last pixel of a frame
//   xPixel, yPixel        horizontal / vertical counters
//   VGA_BLANK_N           DAC blank (active low), follows active_pixels
//   VGA_SYNC_N            DAC sync-on-green (active low)
//
// Optional feature macro: VGA_SYNC_ON_GREEN_EN. When defined, VGA_SYNC_N = hsync & vsync.
// When undefined, VGA_SYNC_N is tied low.
module vga_sync_driver #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       vga_clk,
    output logic       hsync,
    output logic       vsync,
    output logic       active_pixels,
    output logic       frame_done,
    output logic [9:0] xPixel,
    output logic [9:0] yPixel,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Decode boundaries as 10-bit constants so every comparison is width-matched.
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic phase;
    logic tick;

    // Counters step on the second clk of each pixel, i.e. the edge where vga_clk falls,
    // so they are settled by the next vga_clk rising edge the DAC samples on.
    assign tick    = phase;
    assign vga_clk = phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase  <= 1'b0;
            xPixel <= 10'd0;
            yPixel <= 10'd0;
        end else begin
            phase <= ~phase;
            if (tick) begin
                if (xPixel == H_LAST) begin
                    xPixel <= 10'd0;
                    if (yPixel == V_LAST) begin
                        yPixel <= 10'd0;
                    end else begin
                        yPixel <= yPixel + 10'd1;
                    end
                end else begin
                    xPixel <= xPixel + 10'd1;
                end
            end
        end
    end

    assign active_pixels = (xPixel < H_VIS) && (yPixel < V_VIS);
    assign hsync         = !((xPixel >= HS_START) && (xPixel < HS_END));
    assign vsync         = !((yPixel >= VS_START) && (yPixel < VS_END));
    assign VGA_BLANK_N   = active_pixels;

    // Qualified by tick so the strobe covers only the final clk of the last pixel,
    // never both clks of it.
    assign frame_done = tick && (xPixel == H_LAST) && (yPixel == V_LAST);

`ifdef VGA_SYNC_ON_GREEN_EN
    assign VGA_SYNC_N = hsync & vsync;
`else
    assign VGA_SYNC_N = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_driver.sv
// tb_vga_sync_driver: exercises a full-size and a shrunken-geometry vga_sync_driver from a shared clock/reset.
// Expected values come from elapsed-clk arithmetic (pixel = clks/2, x = pixel mod H_TOTAL, ...).
// Random run lengths and asynchronous mid-frame resets are driven with $urandom.
module tb_vga_sync_driver;

    // Full-size geometry.
    localparam int HA = 640, HF = 16, HS = 96, HB = 48;
    localparam int VA = 480, VF = 10, VS = 2,  VB = 33;
    // Shrunken geometry so whole frames fit in a short run.
    localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 2;
    localparam int SVA = 4, SVF = 1, SVS = 2, SVB = 1;
    localparam int S_HT = SHA + SHF + SHS + SHB;   // 15
    localparam int S_VT = SVA + SVF + SVS + SVB;   // 8

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       d_vclk, d_hs, d_vs, d_act, d_fd, d_bn, d_sn;
    logic [9:0] d_x, d_y;
    logic       s_vclk, s_hs, s_vs, s_act, s_fd, s_bn, s_sn;
    logic [9:0] s_x, s_y;

    int checks = 0;
    int errors = 0;
    int c      = 0;     // clk edges seen since the last reset release

    always #5 clk = ~clk;

    vga_sync_driver dut (
        .clk(clk), .rst(rst), .vga_clk(d_vclk), .hsync(d_hs), .vsync(d_vs),
        .active_pixels(d_act), .frame_done(d_fd), .xPixel(d_x), .yPixel(d_y),
        .VGA_BLANK_N(d_bn), .VGA_SYNC_N(d_sn)
    );

    vga_sync_driver #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
    ) dut_s (
        .clk(clk), .rst(rst), .vga_clk(s_vclk), .hsync(s_hs), .vsync(s_vs),
        .active_pixels(s_act), .frame_done(s_fd), .xPixel(s_x), .yPixel(s_y),
        .VGA_BLANK_N(s_bn), .VGA_SYNC_N(s_sn)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (clk %0d)", tag, got, exp, c);
        end
    endtask

    // Reference: n clk edges after release, the pixel index is n/2 and the phase is n%2.
    task automatic model_chk(input string p, input int n,
                             input int ha, input int hf, input int hs, input int hb,
                             input int va, input int vf, input int vs, input int vb,
                             input logic vclk, input logic hsy, input logic vsy,
                             input logic act, input logic fd, input logic bn,
                             input logic sn, input logic [9:0] x, input logic [9:0] y);
        int ht, vt, k, ex, ey;
        logic ph, e_hs, e_vs, e_act, e_fd, e_sn;
        ht    = ha + hf + hs + hb;
        vt    = va + vf + vs + vb;
        k     = n / 2;
        ph    = (n % 2) == 1;
        ex    = k % ht;
        ey    = (k / ht) % vt;
        e_act = (ex < ha) && (ey < va);
        e_hs  = !((ex >= ha + hf) && (ex < ha + hf + hs));
        e_vs  = !((ey >= va + vf) && (ey < va + vf + vs));
        e_fd  = ph && (ex == ht - 1) && (ey == vt - 1);
`ifdef VGA_SYNC_ON_GREEN_EN
        e_sn  = e_hs & e_vs;
`else
        e_sn  = 1'b0;
`endif
        chk({p, "_x"},        32'(x),    32'(ex));
        chk({p, "_y"},        32'(y),    32'(ey));
        chk({p, "_vga_clk"},  32'(vclk), 32'(ph));
        chk({p, "_hsync"},    32'(hsy),  32'(e_hs));
        chk({p, "_vsync"},    32'(vsy),  32'(e_vs));
        chk({p, "_active"},   32'(act),  32'(e_act));
        chk({p, "_blank_n"},  32'(bn),   32'(e_act));
        chk({p, "_frame_done"}, 32'(fd), 32'(e_fd));
        chk({p, "_sync_n"},   32'(sn),   32'(e_sn));
    endtask

    task automatic check_both(input int n);
        model_chk("full", n, HA, HF, HS, HB, VA, VF, VS, VB,
                  d_vclk, d_hs, d_vs, d_act, d_fd, d_bn, d_sn, d_x, d_y);
        model_chk("small", n, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB,
                  s_vclk, s_hs, s_vs, s_act, s_fd, s_bn, s_sn, s_x, s_y);
    endtask

    // Measurement state for the uninterrupted window.
    int full_hs_low = 0;
    int last_fd     = -1;
    int fd_count    = 0;
    int blank_acc   = 0;
    int vs_acc      = 0;
    bit measuring   = 1'b0;

    // Advance one clk, sample 1 ns after the edge, check, and accumulate measurements.
    task automatic step();
        @(posedge clk);
        #1;
        c++;
        check_both(c);
        if (measuring) begin
            if (!d_hs) full_hs_low++;
            if (s_bn)  blank_acc++;
            if (!s_vs) vs_acc++;
            if (s_fd) begin
                fd_count++;
                if (last_fd >= 0) begin
                    chk("small_frame_period", 32'(c - last_fd), 32'(S_HT * S_VT * 2));
                    chk("small_blank_clks",   32'(blank_acc),   32'(SHA * SVA * 2));
                    chk("small_vsync_clks",   32'(vs_acc),      32'(SVS * S_HT * 2));
                end
                last_fd   = c;
                blank_acc = 0;
                vs_acc    = 0;
            end
        end
    endtask

    initial begin
        // Reset held for 5 clk; outputs must show the idle pixel (0,0).
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_both(0);
        rst = 1'b0;
        c   = 0;
        step();
        step();
        chk("first_advance_x", 32'(d_x), 32'd1);

        // Uninterrupted window: 3300 clk covers two full-size lines and ~13 small frames.
        measuring = 1'b1;
        while (c < 3300) step();
        measuring = 1'b0;
        chk("full_hsync_low_clks", 32'(full_hs_low), 32'(2 * HS * 2));
        chk("small_frame_count",   32'(fd_count),    32'(((3300 + 1) / 2) / (S_HT * S_VT)));

        // Random runs interrupted by asynchronous resets landing between clk edges.
        for (int i = 0; i < 20; i++) begin
            int run, hold;
            run  = $urandom_range(40, 900);
            hold = $urandom_range(1, 3);
            repeat (run) step();
            @(posedge clk);
            #($urandom_range(2, 7));
            rst = 1'b1;
            #1;
            c = 0;
            check_both(0);
            repeat (hold) @(posedge clk);
            #1;
            check_both(0);
            rst = 1'b0;
        end
        repeat (500) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
